// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches and decodes 16-bit instructions, then starts one operation FSM
// at a time and waits for its completion, which serialises all register-bus activity.
module instr_sequencer #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 63
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [15:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic [5:0]      Ri,
    output logic [5:0]      Rj,
    output logic            start_move,
    output logic            start_load,
    output logic            start_add,
    output logic            start_sub,
    input  logic            done_move,
    input  logic            done_load,
    input  logic            done_add,
    input  logic            done_sub,
    output logic            busy,
    output logic            halted,
    output logic            error
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, HALT, ERR} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [5:0]      r_ri;
    logic [5:0]      r_rj;
    logic [7:0]      r_cnt;
    logic [3:0]      r_start;
    logic            r_busy;
    logic            r_halted;
    logic            r_error;
    logic [3:0]      w_done_vec;
    logic            w_done;
    assign w_done_vec = {done_sub, done_add, done_load, done_move};
    // Only the completion line of the issued operation is listened to.
    assign w_done     = w_done_vec[r_ir[13:12]];
    assign pc         = r_pc;
    assign Ri         = r_ri;
    assign Rj         = r_rj;
    assign start_move = r_start[0];
    assign start_load = r_start[1];
    assign start_add  = r_start[2];
    assign start_sub  = r_start[3];
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign error      = r_error;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_ri     <= '0;
            r_rj     <= '0;
            r_cnt    <= '0;
            r_start  <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_start <= '0;
            case (r_state)
                IDLE: if (run) begin
                    r_state <= FETCH;
                    r_busy  <= 1'b1;
                end
                FETCH: begin
                    r_ir    <= instr;
                    r_state <= DECODE;
                end
                DECODE: begin
                    r_ri  <= r_ir[11:6];
                    r_rj  <= r_ir[5:0];
                    r_cnt <= '0;
                    if (r_ir[15:14] == 2'b00) begin
                        r_state <= ISSUE;
                        r_start <= 4'b0001 << r_ir[13:12];
                    end else if (&r_ir[15:12]) begin
                        r_state  <= HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= ERR;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_error  <= 1'b1;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (w_done) begin
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= run ? FETCH : IDLE;
                        r_busy  <= run;
                    end else if (r_cnt == LAST) begin
                        r_state  <= ERR;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_error  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
